// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative 32x32 signed multiply / divide unit. Multiply is a
//                32-step shift-add on operand magnitudes; divide is a 32-step
//                restoring shift-subtract. Signs are fixed up on the final
//                edge, when HI/LO are written and done pulses for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  alu_ctr,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] C_OP_MUL   = 4'b1011;
    localparam logic [3:0] C_OP_DIV   = 4'b1100;
    localparam logic [4:0] C_LAST_CNT = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;

    // Latched operation context
    logic        r_is_div;
    logic        r_neg_q;      // sign of product (mul) or quotient (div)
    logic        r_neg_r;      // remainder sign follows the dividend
    logic        r_div_zero;
    logic [31:0] r_opnd;       // multiplicand magnitude (mul) or divisor magnitude (div)

    // Working accumulator: {hi,lo} partial product, or {remainder, dividend/quotient}
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_valid_op;
    logic        w_accept;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    logic [32:0] w_add;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_div_nxt;

    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_valid_op = (alu_ctr == C_OP_MUL) || (alu_ctr == C_OP_DIV);
    assign w_accept   = (r_state == S_IDLE) && start && !flush && w_valid_op;

    // Two's-complement magnitudes; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude.
    assign w_mag_a = op_a[31] ? (32'd0 - op_a) : op_a;
    assign w_mag_b = op_b[31] ? (32'd0 - op_b) : op_b;

    // Shift-add step: add multiplicand when multiplier LSB is set, then shift
    // the 65-bit {carry, hi, lo} right by one.
    assign w_add     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_nxt = {w_add, r_acc_lo[31:1]};

    // Restoring divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. The true difference is always below
    // 2^32 when it fits, so a 32-bit subtract is exact.
    assign w_rem_sh  = {r_acc_hi, r_acc_lo[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    assign w_sub     = w_rem_sh[31:0] - r_opnd;
    assign w_div_nxt = w_ge ? {w_sub, r_acc_lo[30:0], 1'b1}
                            : {w_rem_sh[31:0], r_acc_lo[30:0], 1'b0};

    // Sign fix-up. A zero divisor yields quotient all-ones and the dividend
    // magnitude as remainder, so the remainder fix-up restores op_a exactly.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = r_div_zero ? 32'hFFFF_FFFF
                                   : (r_neg_q ? (32'd0 - r_acc_lo) : r_acc_lo);
    assign w_rem_fix  = r_neg_r ? (32'd0 - r_acc_hi) : r_acc_hi;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_CALC;
            S_CALC:   if (r_cnt == C_LAST_CNT) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Iteration counter: cleared on accept/flush, counts CALC edges and wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 5'd0;
        end else if (flush || w_accept) begin
            r_cnt <= 5'd0;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Operand latch and iterative datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= 32'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
        end else if (w_accept) begin
            r_is_div   <= (alu_ctr == C_OP_DIV);
            r_neg_q    <= op_a[31] ^ op_b[31];
            r_neg_r    <= op_a[31];
            r_div_zero <= (op_b == 32'd0);
            r_acc_hi   <= 32'd0;
            if (alu_ctr == C_OP_DIV) begin
                r_opnd   <= w_mag_b;
                r_acc_lo <= w_mag_a;
            end else begin
                r_opnd   <= w_mag_a;
                r_acc_lo <= w_mag_b;
            end
        end else if ((r_state == S_CALC) && !flush) begin
            if (r_is_div) begin
                {r_acc_hi, r_acc_lo} <= w_div_nxt;
            end else begin
                {r_acc_hi, r_acc_lo} <= w_mul_nxt;
            end
        end
    end

    // HI/LO write and done pulse, only on an unflushed FINISH edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == S_FINISH) && !flush) begin
                r_done <= 1'b1;
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Self-checking bench for mul_div_unit: directed vector table,
//                random operations against a plain-arithmetic model, and
//                hand-written flush / back-to-back / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam logic [3:0] C_MUL = 4'b1011;
    localparam logic [3:0] C_DIV = 4'b1100;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_ctr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_ctr (alu_ctr),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed arithmetic on wide integers
    function automatic void model(input logic [3:0] ctr, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint p;
        int     q;
        int     r;
        if (ctr == C_MUL) begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            h = 32'd0;
            l = 32'h8000_0000;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            h = r;
            l = q;
        end
    endfunction

    // Present a request for one edge (the accepting edge N)
    task automatic issue(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        alu_ctr = ctr;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Count edges until done is seen; flag any non-busy cycle before it
    task automatic wait_done(output int cyc, output logic gap);
        cyc = 0;
        gap = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (done !== 1'b1 && busy !== 1'b1) gap = 1'b1;
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] ctr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int   cyc;
        logic gap;
        issue(ctr, a, b);
        wait_done(cyc, gap);
        chk($sformatf("%s_latency", nm), cyc, 33);
        chk($sformatf("%s_busy_gap", nm), {31'd0, gap}, 32'd0);
        chk($sformatf("%s_busy_at_done", nm), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_hi", nm), hi, ehi);
        chk($sformatf("%s_lo", nm), lo, elo);
        tick();
        chk($sformatf("%s_done_pulse", nm), {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] sv_hi;
        logic [31:0] sv_lo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;
        logic        seen;
        logic        gap;
        int          cyc;

        vecs[0] = '{C_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{C_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[3] = '{C_DIV, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4] = '{C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{C_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[7] = '{C_DIV, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{C_DIV, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[9] = '{C_MUL, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        alu_ctr = 4'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        tick();
        tick();
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ctr, vecs[i].a, vecs[i].b,
                   vecs[i].ehi, vecs[i].elo);
        end

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? C_MUL : C_DIV;
            ra = pick();
            rb = pick();
            model(rc, ra, rb, ehi, elo);
            run_op($sformatf("rnd%0d", i), rc, ra, rb, ehi, elo);
        end

        // Non-operation code is ignored
        issue(4'b0010, 32'd5, 32'd6);
        chk("badop_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("badop_busy2", {31'd0, busy}, 32'd0);

        // Flush at edge N+10
        sv_hi = hi;
        sv_lo = lo;
        issue(C_MUL, 32'd9, 32'd9);
        repeat (9) tick();
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen}, 32'd0);
        chk("flush_hi", hi, sv_hi);
        chk("flush_lo", lo, sv_lo);

        // Flush on the FINISH edge suppresses the write
        issue(C_DIV, 32'd77, 32'd7);
        repeat (32) tick();
        chk("flushfin_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushfin_done", {31'd0, done}, 32'd0);
        chk("flushfin_busy2", {31'd0, busy}, 32'd0);
        chk("flushfin_hi", hi, sv_hi);
        chk("flushfin_lo", lo, sv_lo);

        // Back-to-back: new start in the done cycle, plus an ignored start mid-op
        issue(C_MUL, 32'd3, 32'd4);
        wait_done(cyc, gap);
        chk("b2b_first_lo", lo, 32'd12);
        issue(C_MUL, 32'hFFFF_FFF6, 32'd6);
        repeat (5) tick();
        alu_ctr = C_DIV;
        op_a    = 32'd1000;
        op_b    = 32'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(cyc, gap);
        chk("b2b_latency", cyc + 6, 33);
        chk("b2b_hi", hi, 32'hFFFF_FFFF);
        chk("b2b_lo", lo, 32'hFFFF_FFC4);
        tick();
        chk("b2b_no_extra", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC
        issue(C_DIV, 32'd500, 32'd7);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_hi", hi, 32'd0);
        chk("areset_lo", lo, 32'd0);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("areset_no_resume", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin an operation this cycle.
REQ-004 SHALL have port alu_ctr, input, 4 bits: operation code; 4'b1011 = mul, 4'b1100 = div; all other values are not operations for this block.
REQ-005 SHALL have port op_a, input, 32 bits: signed multiplicand or dividend.
REQ-006 SHALL have port op_b, input, 32 bits: signed multiplier or divisor.
REQ-007 SHALL have port flush, input, 1 bit: pipeline flush; aborts any operation in progress.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE; pipeline stalls dependent mfhi/mflo and new mul/div on it.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO have just been written.
REQ-010 SHALL have port hi, output, 32 bits: HI register (mfhi source).
REQ-011 SHALL have port lo, output, 32 bits: LO register (mflo source).

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FINISH, plus a 5-bit iteration counter.
REQ-013 SHALL accept an operation only when state = IDLE, start = 1, flush = 0 and alu_ctr is 1011 or 1100; at the accepting edge N it SHALL latch opcode, operand magnitudes and result signs, clear counter, enter CALC.
REQ-014 SHALL ignore start with any other alu_ctr value (no state change).
REQ-015 SHALL ignore start while busy = 1; latched operands SHALL NOT change mid-operation.
REQ-016 SHALL run CALC for exactly 32 edges (N+1..N+32): mul = one shift-add step per edge on unsigned magnitudes; div = one restoring shift-subtract step per edge.
REQ-017 SHALL move CALC -> FINISH when counter wraps from 31; FINISH -> IDLE on the next edge (N+33).
REQ-018 SHALL, at edge N+33, apply sign fix-up, write hi/lo and set done = 1 for exactly that one cycle.
REQ-019 SHALL define total latency: start accepted at edge N; results visible and done high after edge N+33; busy high from after edge N until after edge N+33.
REQ-020 SHALL compute mul as the full signed 64-bit product: {hi, lo} = op_a * op_b.
REQ-021 SHALL compute div as lo = quotient truncated toward zero, hi = remainder whose sign follows the dividend.
REQ-022 SHALL, on divisor zero, complete with the same latency and give hi = op_a, lo = 32'hFFFFFFFF; no exception.
REQ-023 SHALL, for 0x80000000 / 0xFFFFFFFF, give lo = 32'h80000000 and hi = 0.
REQ-024 SHALL, with flush = 1 at any edge, force state IDLE and counter 0, leave hi/lo unchanged and keep done = 0; flush SHALL override start and FINISH in the same cycle.
REQ-025 SHALL accept a new start in the cycle done is high, since state is IDLE then.
REQ-026 SHALL leave hi/lo unchanged at every edge except the FINISH edge.

Reset
REQ-027 SHALL, while reset = 1 and regardless of clk, force state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0.
REQ-028 SHALL, on reset during CALC or FINISH, discard the operation with no done pulse; operation SHALL resume only on a fresh start after reset deasserts.

Verification
REQ-029 mul 7 x -3 (op_a=32'h7, op_b=32'hFFFFFFFD) started at edge N -> busy high for 33 cycles; after edge N+33 hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse of one cycle.
REQ-030 div -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; div 7 / -2 -> lo=32'hFFFFFFFD, hi=32'h00000001.
REQ-031 div 100 / 0 -> hi=32'h00000064, lo=32'hFFFFFFFF after 33 cycles; div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-032 mul started at N, flush at edge N+10 -> busy low after N+10, no done, hi/lo keep prior values; start with alu_ctr=4'b0010 -> busy stays 0.
REQ-033 back-to-back: second mul with start held high during the done cycle -> accepted at that edge, second done exactly 33 cycles later; start during busy -> ignored.
REQ-034 reset asserted asynchronously mid-CALC -> hi, lo, busy, done go to 0 immediately without a clock edge; no done after reset release.
